// File: rtl/data_memory.sv
// Line-oriented main-memory model behind the data cache: one whole-line request, fixed latency, one-cycle ack.
// Optional build macro DMEM_RANGE_CHECK_EN: requests with addr_i above the 16 KB window are acked but have no effect.
module data_memory #(
   parameter int MEM_LATENCY = 10,
   parameter int LINE_BITS   = 256,
   parameter int DEPTH       = 512
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [31:0]          addr_i,
   input  logic [LINE_BITS-1:0] data_i,
   input  logic                 enable_i,
   input  logic                 write_i,
   output logic                 ack_o,
   output logic [LINE_BITS-1:0] data_o
);

   localparam int IDX_LSB  = 5;
   localparam int IDX_BITS = $clog2(DEPTH);
   localparam int TAG_LSB  = IDX_LSB + IDX_BITS;
   localparam int CNT_BITS = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   logic [LINE_BITS-1:0] memory [DEPTH];

   state_t               state, next_state;
   logic [CNT_BITS-1:0]  counter, next_counter;
   logic [IDX_BITS-1:0]  lat_idx;
   logic [LINE_BITS-1:0] lat_data;
   logic                 lat_write;
   logic                 lat_oor;
   logic                 req_oor;
   logic                 accept;
   logic                 commit;

`ifdef DMEM_RANGE_CHECK_EN
   logic unused_addr_bits;
   assign req_oor          = |addr_i[31:TAG_LSB];
   assign unused_addr_bits = ^addr_i[IDX_LSB-1:0];
`else
   logic unused_addr_bits;
   assign req_oor          = 1'b0;
   assign unused_addr_bits = ^{addr_i[31:TAG_LSB], addr_i[IDX_LSB-1:0]};
`endif

   always_comb begin
      next_state   = state;
      next_counter = counter;
      accept       = 1'b0;
      commit       = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable_i) begin
               accept       = 1'b1;
               next_counter = CNT_BITS'(1);
               next_state   = BUSY;
            end
         end
         BUSY: begin
            // Completion is taken on the edge where counter already holds MEM_LATENCY-1,
            // which puts the ack pulse MEM_LATENCY-1 edges after acceptance.
            if (counter == CNT_LAST) begin
               commit     = 1'b1;
               next_state = DONE;
            end else begin
               next_counter = counter + 1'b1;
            end
         end
         DONE: begin
            next_counter = '0;
            next_state   = IDLE;
         end
         default: begin
            next_counter = '0;
            next_state   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         counter   <= '0;
         ack_o     <= 1'b0;
         data_o    <= '0;
         lat_idx   <= '0;
         lat_data  <= '0;
         lat_write <= 1'b0;
         lat_oor   <= 1'b0;
      end else begin
         state   <= next_state;
         counter <= next_counter;
         ack_o   <= commit;
         if (accept) begin
            lat_idx   <= addr_i[IDX_LSB +: IDX_BITS];
            lat_data  <= data_i;
            lat_write <= write_i;
            lat_oor   <= req_oor;
         end
         if (commit && !lat_write) begin
            data_o <= lat_oor ? '0 : memory[lat_idx];
         end
      end
   end

   // Contents survive reset; an aborted request never reaches commit, so nothing is written.
   always_ff @(posedge clk_i) begin
      if (commit && lat_write && !lat_oor) begin
         memory[lat_idx] <= lat_data;
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed vector table, multi-cycle corner sequences, random traffic vs. a line-array model.
module tb_data_memory;

   localparam int LAT = 10;

`ifdef DMEM_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [31:0]  addr_i;
   logic [255:0] data_i;
   logic         enable_i;
   logic         write_i;
   logic         ack_o;
   logic [255:0] data_o;

   int tests = 0;
   int fails = 0;

   logic [255:0] model_mem [512];
   logic [255:0] exp_dout;

   typedef struct {
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] wdata;
      logic [255:0] exp_dout;
   } vec_t;

   vec_t vecs [7];

   data_memory #(.MEM_LATENCY(LAT), .LINE_BITS(256), .DEPTH(512)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .addr_i   (addr_i),
      .data_i   (data_i),
      .enable_i (enable_i),
      .write_i  (write_i),
      .ack_o    (ack_o),
      .data_o   (data_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Reference behaviour: line = (addr / 32) mod 512; out-of-window requests only matter when range check is built in.
   task automatic model_access(input bit wr, input logic [31:0] a, input logic [255:0] d);
      int unsigned idx;
      bit inrange;
      idx = (a / 32) % 512;
      inrange = !RC || ((a / 16384) == 0);
      if (wr) begin
         if (inrange) model_mem[idx] = d;
      end else begin
         exp_dout = inrange ? model_mem[idx] : '0;
      end
   endtask

   // Issues one single-cycle request and returns the cycle (1-based after sampling) in which ack_o was seen; 0 = timeout.
   task automatic do_req(input bit wr, input logic [31:0] a, input logic [255:0] d, output int lat);
      @(negedge clk_i);
      enable_i = 1'b1; write_i = wr; addr_i = a; data_i = d;
      @(posedge clk_i);
      @(negedge clk_i);
      enable_i = 1'b0;
      write_i  = ~wr;
      addr_i   = $urandom;
      data_i   = {8{$urandom}};
      lat = 0;
      for (int c = 1; c <= 3 * LAT; c++) begin
         if (ack_o === 1'b1) begin
            lat = c;
            break;
         end
         @(negedge clk_i);
      end
   endtask

   task automatic run_and_check(input string name, input bit wr, input logic [31:0] a, input logic [255:0] d,
                                input logic [255:0] req_dout);
      int lat;
      do_req(wr, a, d, lat);
      check({name, " latency"}, 256'(lat), 256'(LAT));
      check({name, " data_o"}, data_o, req_dout);
      @(negedge clk_i);
      check({name, " ack low after"}, 256'(ack_o), 256'(0));
   endtask

   initial begin
      int ack_cycles [2];
      int nacks;
      int lines_bad;
      logic [255:0] old3;

      rst_i = 1'b1; enable_i = 1'b0; write_i = 1'b0; addr_i = '0; data_i = '0;
      exp_dout = '0;
      #1;
      check("reset ack_o", 256'(ack_o), 256'(0));
      check("reset data_o", data_o, '0);

      for (int i = 0; i < 512; i++) begin
         model_mem[i] = {8{$urandom}};
         dut.memory[i] = model_mem[i];
      end
      model_mem[0] = 256'h5;
      dut.memory[0] = 256'h5;

      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;

      vecs[0] = '{1'b0, 32'h0000_0000, '0,            256'h5};
      vecs[1] = '{1'b1, 32'h0000_0020, 256'hDEADBEEF, 256'h5};
      vecs[2] = '{1'b0, 32'h0000_0020, '0,            256'hDEADBEEF};
      vecs[3] = '{1'b0, 32'h0000_001F, '0,            256'h5};
      vecs[4] = '{1'b1, 32'h0000_4000, 256'h7,        256'h5};
      vecs[5] = '{1'b0, 32'h0000_0000, '0,            RC ? 256'h5 : 256'h7};
      vecs[6] = '{1'b0, 32'h0000_4000, '0,            RC ? 256'h0 : 256'h7};

      for (int v = 0; v < 7; v++) begin
         model_access(vecs[v].wr, vecs[v].addr, vecs[v].wdata);
         run_and_check($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].exp_dout);
      end
      exp_dout = vecs[6].exp_dout;
      check("memory[1] after write", dut.memory[1], 256'hDEADBEEF);
      check("memory[0] after alias write", dut.memory[0], RC ? 256'h5 : 256'h7);

      // Held request: re-acceptance only after DONE->IDLE, so acks are MEM_LATENCY+1 apart.
      @(negedge clk_i);
      enable_i = 1'b1; write_i = 1'b0; addr_i = 32'h40;
      nacks = 0;
      ack_cycles[0] = 0; ack_cycles[1] = 0;
      for (int c = 0; c <= 4 * LAT && nacks < 2; c++) begin
         if (c > 0) @(negedge clk_i);
         if (ack_o === 1'b1) begin
            ack_cycles[nacks] = c;
            nacks++;
         end
      end
      enable_i = 1'b0;
      model_access(1'b0, 32'h40, '0);
      check("held: ack count", 256'(nacks), 256'(2));
      check("held: first ack cycle", 256'(ack_cycles[0]), 256'(LAT));
      check("held: ack spacing", 256'(ack_cycles[1] - ack_cycles[0]), 256'(LAT + 1));
      check("held: data_o", data_o, exp_dout);
      repeat (3) @(negedge clk_i);
      check("held: no extra ack", 256'(ack_o), 256'(0));

      // Reset in the 5th cycle of a write aborts it.
      old3 = model_mem[3];
      @(negedge clk_i);
      enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h60; data_i = ~old3;
      @(posedge clk_i);
      @(negedge clk_i);
      enable_i = 1'b0;
      repeat (4) @(negedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      check("abort: ack_o in reset", 256'(ack_o), 256'(0));
      check("abort: data_o in reset", data_o, '0);
      @(negedge clk_i);
      rst_i = 1'b0;
      exp_dout = '0;
      nacks = 0;
      for (int c = 0; c < 2 * LAT; c++) begin
         @(negedge clk_i);
         if (ack_o === 1'b1) nacks++;
      end
      check("abort: no ack", 256'(nacks), 256'(0));
      check("abort: memory[3] unchanged", dut.memory[3], old3);
      model_access(1'b0, 32'h60, '0);
      run_and_check("abort: follow-up read", 1'b0, 32'h60, '0, exp_dout);

      // Random traffic, half the addresses confined to the 16 KB window.
      for (int n = 0; n < 40; n++) begin
         bit wr;
         logic [31:0] a;
         logic [255:0] d;
         wr = 1'($urandom_range(0, 1));
         a  = $urandom;
         if ($urandom_range(0, 1) == 0) a = a & 32'h0000_3FFF;
         d  = {8{$urandom}};
         model_access(wr, a, d);
         run_and_check($sformatf("rand%0d", n), wr, a, d, exp_dout);
      end

      lines_bad = 0;
      for (int i = 0; i < 512; i++) begin
         if (dut.memory[i] !== model_mem[i]) lines_bad++;
      end
      check("final memory lines differing", 256'(lines_bad), 256'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
